mult_div_unit: RTL and testbench

//   Multicycle signed multiply/divide unit for the MIPS multicycle CPU.
//   - Takes its operands from the A and B register outputs.
//   - Produces the HI/LO values that feed the write-data mux, used by mfhi/mflo.
//   - The control FSM starts an operation with a one-cycle pulse, stalls while busy=1,
//     and resumes on done.

---
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Multicycle signed multiply (radix-2 Booth) / divide (restoring)
//             producing HI/LO for mfhi/mflo.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  // r_acc: Booth accumulator (sign-extended) in MULT, partial remainder in DIV.
  // r_q:   multiplier shifting out in MULT, dividend shifting out / quotient in in DIV.
  // r_m:   multiplicand in MULT, divisor magnitude in DIV.
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_m;
  logic               r_qm1;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_booth_sum;
  logic [WIDTH:0]     w_booth_acc;
  logic [WIDTH-1:0]   w_booth_q;
  logic [WIDTH:0]     w_div_shl;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH:0]     w_div_rem;
  logic [WIDTH-1:0]   w_div_quot;

  // Two's-complement negation read back as unsigned keeps the most negative value exact.
  assign w_a_mag = a_in[WIDTH-1] ? (~a_in + WIDTH'(1)) : a_in;
  assign w_b_mag = b_in[WIDTH-1] ? (~b_in + WIDTH'(1)) : b_in;

  always_comb begin
    w_m_ext = {r_m[WIDTH-1], r_m};
    case ({r_q[0], r_qm1})
      2'b01:   w_booth_sum = r_acc + w_m_ext;
      2'b10:   w_booth_sum = r_acc - w_m_ext;
      default: w_booth_sum = r_acc;
    endcase
    w_booth_acc = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
    w_booth_q   = {w_booth_sum[0], r_q[WIDTH-1:1]};
  end

  always_comb begin
    w_div_shl  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    w_div_diff = w_div_shl - {1'b0, r_m};
    w_div_ge   = ~w_div_diff[WIDTH];
    w_div_rem  = w_div_ge ? w_div_diff : w_div_shl;
    w_div_quot = {r_q[WIDTH-2:0], w_div_ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    div_zero    = r_div_zero;
    case (r_state)
      S_IDLE: begin
        if (start_mult)                    w_state_nxt = S_MULT;
        else if (start_div && b_in != '0)  w_state_nxt = S_DIV;
        else if (start_div)                w_state_nxt = S_DONE;
      end
      S_MULT:  if (r_cnt == c_cnt_last) w_state_nxt = S_DONE;
      S_DIV:   if (r_cnt == c_cnt_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_qm1      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      hi_out     <= '0;
      lo_out     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_mult) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_q   <= b_in;
            r_m   <= a_in;
            r_qm1 <= 1'b0;
          end else if (start_div && b_in != '0) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= w_a_mag;
            r_m     <= w_b_mag;
            r_neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            r_neg_r <= a_in[WIDTH-1];
          end else if (start_div) begin
            r_div_zero <= 1'b1;
          end
        end
        S_MULT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= w_booth_acc;
          r_q   <= w_booth_q;
          r_qm1 <= r_q[0];
          if (r_cnt == c_cnt_last) begin
            hi_out <= w_booth_acc[WIDTH-1:0];
            lo_out <= w_booth_q;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= w_div_rem;
          r_q   <= w_div_quot;
          if (r_cnt == c_cnt_last) begin
            lo_out <= r_neg_q ? (~w_div_quot + WIDTH'(1)) : w_div_quot;
            hi_out <= r_neg_r ? (~w_div_rem[WIDTH-1:0] + WIDTH'(1)) : w_div_rem[WIDTH-1:0];
          end
        end
        default: r_div_zero <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Self-checking bench for mult_div_unit against a 64-bit
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return x * y;
  endfunction

  // Returns {remainder, quotient}; 64-bit math avoids the MIN/-1 overflow.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz);
    @(negedge clk);
    start_mult = m; start_div = d; a_in = a; b_in = b;
    @(negedge clk);
    start_mult = 1'b0; start_div = 1'b0;
    a_in = $urandom; b_in = $urandom;
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    hi = hi_out; lo = lo_out; dz = div_zero;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (hi_out !== 32'h0) $display("FAIL reset_hi got %h want 0", hi_out); else n_pass++;
    n_checks++; if (lo_out !== 32'h0) $display("FAIL reset_lo got %h want 0", lo_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_zero); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_mult;
    logic [31:0] av [0:13];
    logic [31:0] bv [0:13];
    logic [31:0] hi, lo;
    logic [63:0] p;
    logic        dz;
    int          n;
    av[0] = 32'd7;        bv[0] = 32'hFFFFFFFD;
    av[1] = 32'h80000000; bv[1] = 32'h80000000;
    for (int i = 2; i < 14; i++) begin
      av[i] = $urandom; bv[i] = $urandom;
      if (i == 2) bv[i] = 32'hFFFFFFFF;
      if (i == 3) av[i] = 32'h0;
    end
    for (int i = 0; i < 14; i++) begin
      run_op(1'b1, 1'b0, av[i], bv[i], n, hi, lo, dz);
      p = ref_mult(av[i], bv[i]);
      exp_hi = p[63:32]; exp_lo = p[31:0];
      n_checks++; if (n !== 33) $display("FAIL mult_latency[%0d] got %0d want 33", i, n); else n_pass++;
      n_checks++; if (hi !== exp_hi) $display("FAIL mult_hi[%0d] a=%h b=%h got %h want %h", i, av[i], bv[i], hi, exp_hi); else n_pass++;
      n_checks++; if (lo !== exp_lo) $display("FAIL mult_lo[%0d] a=%h b=%h got %h want %h", i, av[i], bv[i], lo, exp_lo); else n_pass++;
      n_checks++; if (dz !== 1'b0) $display("FAIL mult_dz[%0d] got %b want 0", i, dz); else n_pass++;
      @(negedge clk);
      n_checks++; if ({done, busy} !== 2'b00) $display("FAIL mult_after_done[%0d] got done,busy=%b want 00", i, {done, busy}); else n_pass++;
    end
  endtask

  task automatic test_div;
    logic [31:0] av [0:13];
    logic [31:0] bv [0:13];
    logic [31:0] hi, lo;
    logic [63:0] r;
    logic        dz;
    int          n;
    av[0] = 32'hFFFFFFF9; bv[0] = 32'd2;
    av[1] = 32'h80000000; bv[1] = 32'hFFFFFFFF;
    av[2] = 32'h80000000; bv[2] = 32'h80000000;
    av[3] = 32'd3;        bv[3] = 32'hFFFFFFF6;
    for (int i = 4; i < 14; i++) begin
      av[i] = $urandom;
      bv[i] = (i % 2 == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      if (bv[i] == 32'h0) bv[i] = 32'd13;
    end
    for (int i = 0; i < 14; i++) begin
      run_op(1'b0, 1'b1, av[i], bv[i], n, hi, lo, dz);
      r = ref_div(av[i], bv[i]);
      exp_hi = r[63:32]; exp_lo = r[31:0];
      n_checks++; if (n !== 33) $display("FAIL div_latency[%0d] got %0d want 33", i, n); else n_pass++;
      n_checks++; if (hi !== exp_hi) $display("FAIL div_hi[%0d] a=%h b=%h got %h want %h", i, av[i], bv[i], hi, exp_hi); else n_pass++;
      n_checks++; if (lo !== exp_lo) $display("FAIL div_lo[%0d] a=%h b=%h got %h want %h", i, av[i], bv[i], lo, exp_lo); else n_pass++;
      n_checks++; if (dz !== 1'b0) $display("FAIL div_dz[%0d] got %b want 0", i, dz); else n_pass++;
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] hi, lo;
    logic        dz;
    int          n;
    run_op(1'b0, 1'b1, 32'd5, 32'd0, n, hi, lo, dz);
    n_checks++; if (n !== 1) $display("FAIL dz_latency got %0d want 1", n); else n_pass++;
    n_checks++; if (dz !== 1'b1) $display("FAIL dz_flag got %b want 1", dz); else n_pass++;
    n_checks++; if (hi !== exp_hi) $display("FAIL dz_hi_kept got %h want %h", hi, exp_hi); else n_pass++;
    n_checks++; if (lo !== exp_lo) $display("FAIL dz_lo_kept got %h want %h", lo, exp_lo); else n_pass++;
    @(negedge clk);
    n_checks++; if ({done, busy, div_zero} !== 3'b000) $display("FAIL dz_after got done,busy,dz=%b want 000", {done, busy, div_zero}); else n_pass++;
  endtask

  task automatic test_ignore_start;
    logic [63:0] r;
    int          n, extra;
    @(negedge clk);
    start_div = 1'b1; a_in = 32'hFFFFFF9C; b_in = 32'd7;
    @(negedge clk);
    start_div = 1'b0; a_in = 32'd1234; b_in = 32'd5678;
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      if (n == 10) start_mult = 1'b1;
      @(negedge clk);
      start_mult = 1'b0;
      n++;
    end
    r = ref_div(32'hFFFFFF9C, 32'd7);
    exp_hi = r[63:32]; exp_lo = r[31:0];
    n_checks++; if (n !== 33) $display("FAIL ign_latency got %0d want 33", n); else n_pass++;
    n_checks++; if (hi_out !== exp_hi) $display("FAIL ign_hi got %h want %h", hi_out, exp_hi); else n_pass++;
    n_checks++; if (lo_out !== exp_lo) $display("FAIL ign_lo got %h want %h", lo_out, exp_lo); else n_pass++;
    extra = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL ign_extra_done got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_both_starts;
    logic [31:0] hi, lo;
    logic [63:0] p;
    logic        dz;
    int          n, extra;
    run_op(1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, n, hi, lo, dz);
    p = ref_mult(32'hDEADBEEF, 32'h12345678);
    exp_hi = p[63:32]; exp_lo = p[31:0];
    n_checks++; if (n !== 33) $display("FAIL both_latency got %0d want 33", n); else n_pass++;
    n_checks++; if ({hi, lo} !== p) $display("FAIL both_result got %h want %h", {hi, lo}, p); else n_pass++;
    extra = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL both_extra_done got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_reset_midop;
    logic [31:0] hi, lo;
    logic [63:0] p;
    logic        dz;
    int          n, extra;
    @(negedge clk);
    start_mult = 1'b1; a_in = 32'h7FFFFFFF; b_in = 32'h00000003;
    @(negedge clk);
    start_mult = 1'b0;
    n = 1;
    while (n < 15) begin @(negedge clk); n++; end
    reset = 1'b1;
    #1;
    n_checks++; if ({hi_out, lo_out} !== 64'h0) $display("FAIL rst_mid_hilo got %h want 0", {hi_out, lo_out}); else n_pass++;
    n_checks++; if ({busy, done, div_zero} !== 3'b000) $display("FAIL rst_mid_flags got %b want 000", {busy, done, div_zero}); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    extra = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL rst_mid_activity got %0d want 0", extra); else n_pass++;
    run_op(1'b1, 1'b0, 32'hFFFFFFF0, 32'h00000011, n, hi, lo, dz);
    p = ref_mult(32'hFFFFFFF0, 32'h00000011);
    exp_hi = p[63:32]; exp_lo = p[31:0];
    n_checks++; if (n !== 33) $display("FAIL rst_next_latency got %0d want 33", n); else n_pass++;
    n_checks++; if ({hi, lo} !== p) $display("FAIL rst_next_result got %h want %h", {hi, lo}, p); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] hi, lo;
    logic [63:0] r;
    logic        dz;
    int          n, extra;
    run_op(1'b1, 1'b0, 32'd100, 32'd200, n, hi, lo, dz);
    // Start during the done cycle must be ignored.
    start_div = 1'b1; a_in = 32'd50; b_in = 32'd3;
    @(negedge clk);
    start_div = 1'b0;
    extra = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) extra++; end
    n_checks++; if (extra !== 0) $display("FAIL b2b_start_in_done got %0d dones want 0", extra); else n_pass++;
    n_checks++; if ({hi_out, lo_out} !== 64'd20000) $display("FAIL b2b_hold got %h want %h", {hi_out, lo_out}, 64'd20000); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 1'b1, 32'd1000 + 32'(i), 32'hFFFFFFFD, n, hi, lo, dz);
      r = ref_div(32'd1000 + 32'(i), 32'hFFFFFFFD);
      n_checks++; if ({hi, lo} !== r) $display("FAIL b2b_div[%0d] got %h want %h", i, {hi, lo}, r); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_both_starts();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
